// File: rtl/ahb_pkg.sv
// AHB protocol constants shared with the master interface, plus the read-lane extractor.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_B8  = 3'b000;
    localparam logic [2:0] HSIZE_B16 = 3'b001;
    localparam logic [2:0] HSIZE_B32 = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam int unsigned DATA_W = 32;

    // Zero-extended byte/halfword lane; unknown sizes are treated as a full word.
    function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] data,
                                                       input logic [1:0] lane,
                                                       input logic [2:0] size);
        logic [DATA_W-1:0] res;
        res = data;
        if (size == HSIZE_B8) begin
            case (lane)
                2'd0:    res = {24'h0, data[7:0]};
                2'd1:    res = {24'h0, data[15:8]};
                2'd2:    res = {24'h0, data[23:16]};
                default: res = {24'h0, data[31:24]};
            endcase
        end else if (size == HSIZE_B16) begin
            res = lane[1] ? {16'h0, data[31:16]} : {16'h0, data[15:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/rdbuf_fifo.sv
// Register-array FIFO holding extracted read beats; show-ahead head on rdata.
module rdbuf_fifo
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage array carries no reset; occupancy is tracked by level alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/ahb_rdbuf.sv
// AHB read-data input buffer: tracks the address/data pipeline and queues the
// addressed lane of each completed read beat for the rotate core.
module ahb_rdbuf
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned AFULL_TH = 12
) (
    input  logic              I_RDBUF_HCLK,
    input  logic              I_RDBUF_HRESET,
    input  logic              I_RDBUF_RESET,
    input  logic [1:0]        I_RDBUF_HTRANS,
    input  logic [1:0]        I_RDBUF_HADDR,
    input  logic [2:0]        I_RDBUF_HSIZE,
    input  logic              I_RDBUF_HWRITE,
    input  logic              I_RDBUF_HREADY,
    input  logic [DATA_W-1:0] I_RDBUF_HRDATA,
    input  logic              I_RDBUF_POP,
    output logic [DATA_W-1:0] O_RDBUF_DATA,
    output logic              O_RDBUF_VALID,
    output logic              O_RDBUF_FULL,
    output logic              O_RDBUF_AFULL,
    output logic [AW:0]       O_RDBUF_LEVEL,
    output logic              O_RDBUF_OVF
);

    logic              pend;
    logic [1:0]        lane;
    logic [2:0]        size;
    logic              ovf;
    logic              read_req;
    logic              beat;
    logic              pop_ok;
    logic              push;
    logic [DATA_W-1:0] head;
    logic [AW:0]       level;
    logic              full;
    logic              empty;

    assign read_req = ((I_RDBUF_HTRANS == HTRANS_NSEQ) || (I_RDBUF_HTRANS == HTRANS_SEQ))
                      && !I_RDBUF_HWRITE;
    assign beat     = pend && I_RDBUF_HREADY;
    assign pop_ok   = I_RDBUF_POP && !empty;
    // A full queue still accepts a beat when the head leaves in the same cycle.
    assign push     = beat && (!full || pop_ok) && !I_RDBUF_RESET;

    // Address-phase tracker; wait states hold the pending data phase.
    always_ff @(posedge I_RDBUF_HCLK or posedge I_RDBUF_HRESET) begin
        if (I_RDBUF_HRESET) begin
            pend <= 1'b0;
            lane <= '0;
            size <= '0;
            ovf  <= 1'b0;
        end else if (I_RDBUF_RESET) begin
            pend <= 1'b0;
            lane <= '0;
            size <= '0;
            ovf  <= 1'b0;
        end else begin
            if (I_RDBUF_HREADY) begin
                pend <= read_req;
                if (read_req) begin
                    lane <= I_RDBUF_HADDR;
                    size <= I_RDBUF_HSIZE;
                end
            end
            if (beat && full && !pop_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    rdbuf_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (I_RDBUF_HCLK),
        .rst   (I_RDBUF_HRESET),
        .flush (I_RDBUF_RESET),
        .push  (push),
        .pop   (pop_ok),
        .wdata (lane_extract(I_RDBUF_HRDATA, lane, size)),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Status is decoded from the registered level; stale array contents are masked.
    assign O_RDBUF_DATA  = empty ? '0 : head;
    assign O_RDBUF_VALID = !empty;
    assign O_RDBUF_FULL  = full;
    assign O_RDBUF_AFULL = (level >= (AW+1)'(AFULL_TH));
    assign O_RDBUF_LEVEL = level;
    assign O_RDBUF_OVF   = ovf;

endmodule
